// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: clock divider, h/v counters and a registered sync/colour stage.
// Define VGA_TEST_PATTERN_EN to replace rgb_i with eight internally generated colour bars.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [2:0]       rgb_i,
  output logic             pix_tick_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             de_o,
  output logic             frame_start_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             r_o,
  output logic             g_o,
  output logic             b_o
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HsStart = H_ACTIVE + H_FP;
  localparam int unsigned HsEnd   = HsStart + H_SYNC;
  localparam int unsigned VsStart = V_ACTIVE + V_FP;
  localparam int unsigned VsEnd   = VsStart + V_SYNC;
  localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DivW-1:0]  div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic [2:0]       rgb_q, rgb_d;

  logic       pix_tick, de, h_last, v_last, hsync_act, vsync_act;
  logic [2:0] pix_rgb;

  always_comb begin
    pix_tick  = (div_cnt_q == DivW'(CLK_DIV - 1));
    h_last    = (h_cnt_q == CNT_W'(H_TOTAL - 1));
    v_last    = (v_cnt_q == CNT_W'(V_TOTAL - 1));
    de        = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));
    hsync_act = (h_cnt_q >= CNT_W'(HsStart)) && (h_cnt_q < CNT_W'(HsEnd));
    vsync_act = (v_cnt_q >= CNT_W'(VsStart)) && (v_cnt_q < CNT_W'(VsEnd));
  end

  always_comb begin
    div_cnt_d = div_cnt_q + DivW'(1);
    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    if (rst_i) begin
      div_cnt_d = '0;
      h_cnt_d   = '0;
      v_cnt_d   = '0;
    end else if (pix_tick) begin
      div_cnt_d = '0;
      h_cnt_d   = h_last ? '0 : h_cnt_q + CNT_W'(1);
      if (h_last) begin
        v_cnt_d = v_last ? '0 : v_cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BarLen = H_ACTIVE / 8;

  logic [2:0]       bar_q, bar_d;
  logic [CNT_W-1:0] bar_pix_q, bar_pix_d;
  logic             unused_rgb;

  // bar_q always holds the bar index of the pixel currently at h_cnt.
  always_comb begin
    unused_rgb = ^rgb_i;
    bar_d      = bar_q;
    bar_pix_d  = bar_pix_q;
    if (rst_i || (pix_tick && h_last)) begin
      bar_d     = '0;
      bar_pix_d = '0;
    end else if (pix_tick && de) begin
      if (bar_pix_q == CNT_W'(BarLen - 1)) begin
        bar_pix_d = '0;
        bar_d     = bar_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + CNT_W'(1);
      end
    end
    pix_rgb = bar_q;
  end

  always_ff @(posedge clk_i) begin
    bar_q     <= bar_d;
    bar_pix_q <= bar_pix_d;
  end
`else
  always_comb begin
    pix_rgb = rgb_i;
  end
`endif

  // Output stage: sync and colour are registered together so they stay aligned.
  always_comb begin
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    rgb_d   = rgb_q;
    if (rst_i) begin
      hsync_d = ~HSYNC_POL;
      vsync_d = ~VSYNC_POL;
      rgb_d   = 3'b000;
    end else if (pix_tick) begin
      hsync_d = hsync_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = vsync_act ? VSYNC_POL : ~VSYNC_POL;
      rgb_d   = de ? pix_rgb : 3'b000;
    end
  end

  always_ff @(posedge clk_i) begin
    div_cnt_q <= div_cnt_d;
    h_cnt_q   <= h_cnt_d;
    v_cnt_q   <= v_cnt_d;
    hsync_q   <= hsync_d;
    vsync_q   <= vsync_d;
    rgb_q     <= rgb_d;
  end

  always_comb begin
    pix_tick_o    = pix_tick;
    x_o           = h_cnt_q;
    y_o           = v_cnt_q;
    de_o          = de;
    frame_start_o = pix_tick && (h_cnt_q == '0) && (v_cnt_q == '0);
    hsync_o       = hsync_q;
    vsync_o       = vsync_q;
    {r_o, g_o, b_o} = rgb_q;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a shrunken raster (24x13 total, 16x8 active, div 2).
module tb_vga_timing_gen;

  localparam int unsigned ClkDiv = 2;
  localparam int unsigned HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VA = 8, VF = 1, VS = 2, VB = 2;
  localparam int unsigned CntW = 10;
  localparam int unsigned HT = 24, VT = 13;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      rgb = 3'b000;
  logic            pix_tick, de, frame_start, hsync, vsync, r, g, b;
  logic [CntW-1:0] x, y;

  int n_cmp = 0, n_bad = 0;
  int n_col7, n_hlow, n_vlow, n_fs;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(ClkDiv), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(CntW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rgb_i(rgb), .pix_tick_o(pix_tick), .x_o(x), .y_o(y),
    .de_o(de), .frame_start_o(frame_start), .hsync_o(hsync), .vsync_o(vsync),
    .r_o(r), .g_o(g), .b_o(b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Wait for the next tick, present rgb_val, take the tick edge and check the registered result.
  task automatic next_pixel(input logic [2:0] rgb_val);
    int waited = 0;
    logic [CntW-1:0] px, py, ex, ey;
    logic exp_de;
    logic [2:0] exp_col;
    while (pix_tick !== 1'b1 && waited <= ClkDiv) begin
      cyc();
      waited++;
    end
    check("tick_spacing", waited, ClkDiv - 1);
    if (pix_tick !== 1'b1) begin
      $display("FAIL tick_timeout: observed no tick, required a tick within %0d clocks", ClkDiv);
      $fatal(1, "no pixel tick");
    end
    px = x;
    py = y;
    rgb = rgb_val;
    exp_de = (px < HA) && (py < VA);
    check("de", de, exp_de);
    check("frame_start", frame_start, (px == 0) && (py == 0));
    if (frame_start) n_fs++;
`ifdef VGA_TEST_PATTERN_EN
    exp_col = exp_de ? 3'(px / (HA / 8)) : 3'b000;
`else
    exp_col = exp_de ? rgb_val : 3'b000;
`endif
    ex = (px == HT - 1) ? '0 : px + 1;
    ey = (px == HT - 1) ? ((py == VT - 1) ? '0 : py + 1) : py;
    cyc();
    check("hsync", hsync, !((px >= HA + HF) && (px < HA + HF + HS)));
    check("vsync", vsync, !((py >= VA + VF) && (py < VA + VF + VS)));
    check("colour", {r, g, b}, exp_col);
    check("x_next", x, ex);
    check("y_next", y, ey);
    check("tick_low", pix_tick, 1'b0);
    if ({r, g, b} == 3'b111) n_col7++;
    if (!hsync) n_hlow++;
    if (!vsync) n_vlow++;
  endtask

  // One full frame with white input, then the per-frame totals.
  task automatic run_frame();
    n_col7 = 0; n_hlow = 0; n_vlow = 0; n_fs = 0;
    for (int i = 0; i < HT * VT; i++) next_pixel(3'b111);
`ifdef VGA_TEST_PATTERN_EN
    check("frame_white_px", n_col7, 16);
`else
    check("frame_white_px", n_col7, 128);
`endif
    check("frame_hsync_low", n_hlow, 39);
    check("frame_vsync_low", n_vlow, 48);
    check("frame_starts", n_fs, 1);
    check("frame_end_x", x, 0);
    check("frame_end_y", y, 0);
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_hsync", hsync, 1'b1);
    check("rst_vsync", vsync, 1'b1);
    check("rst_rgb", {r, g, b}, 3'b000);
    check("rst_tick", pix_tick, 1'b0);
    rst = 1'b0;
    check("rel_cycle0_tick", pix_tick, 1'b0);

    run_frame();

    // Random colours across the raster until the mid-frame reset point inside both syncs.
    for (int i = 0; i < HT * VT && !(x == 19 && y == 9); i++) next_pixel(3'($urandom_range(0, 7)));
    check("mid_point", {y, x}, {10'd9, 10'd19});
    check("mid_hsync_low", hsync, 1'b0);
    check("mid_vsync_low", vsync, 1'b0);

    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check("mid_rst_x", x, 0);
    check("mid_rst_y", y, 0);
    check("mid_rst_hsync", hsync, 1'b1);
    check("mid_rst_vsync", vsync, 1'b1);
    check("mid_rst_rgb", {r, g, b}, 3'b000);
    check("mid_rst_tick", pix_tick, 1'b0);

    run_frame();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
